// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract sequencer driving one external 1-bit full adder, LSB first.
// Optional signed-overflow flag and OVF port: define OVF_FLAG_EN.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_CIN,
  input  logic             FA_S,
  input  logic             FA_COUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
`ifdef OVF_FLAG_EN
  output logic             OVF,
`endif
  output logic             COUT
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             accept, last_bit;
`ifdef OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  assign accept   = (state_q == S_IDLE) && START;
  assign last_bit = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
`ifdef OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY   = (state_q == S_RUN);
    DONE   = (state_q == S_FIN);
    FA_A   = 1'b0;
    FA_B   = 1'b0;
    FA_CIN = 1'b0;
    if (state_q == S_RUN) begin
      FA_A   = opa_q[0];
      FA_B   = opb_q[0];
      FA_CIN = carry_q;
    end
  end

  // Subtraction is A + ~B + 1: B is inverted on load and the carry seeded with SUB.
  always_comb begin
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef OVF_FLAG_EN
    ovf_d    = ovf_q;
`endif
    if (accept) begin
      opa_d   = A;
      opb_d   = SUB ? ~B : B;
      carry_d = SUB;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      carry_d  = FA_COUT;
      opa_d    = opa_q >> 1;
      opb_d    = opb_q >> 1;
      result_d = {FA_S, result_q[WIDTH-1:1]};
      cnt_d    = cnt_q + 1'b1;
      if (last_bit) begin
        cout_d = FA_COUT;
`ifdef OVF_FLAG_EN
        ovf_d  = carry_q ^ FA_COUT;
`endif
      end
    end
  end

  assign RESULT = result_q;
  assign COUT   = cout_q;
`ifdef OVF_FLAG_EN
  assign OVF    = ovf_q;
`endif
endmodule
